// File: rtl/rv_ahb_pkg.sv
// Shared AHB definitions for the SRAM slave: transfer types, response codes,
// data-phase FSM states and the wait-counter width.
// Optional feature macro: RV_AHB_SLV_ERR_EN adds the two-cycle ERROR states.
package rv_ahb_pkg;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'b00,
        TRANS_BUSY   = 2'b01,
        TRANS_NONSEQ = 2'b10,
        TRANS_SEQ    = 2'b11
    } trans_t;

    typedef enum logic {
        RESP_OKAY  = 1'b0,
        RESP_ERROR = 1'b1
    } resp_t;

`ifdef RV_AHB_SLV_ERR_EN
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAITING = 3'd1,
        ST_LAST    = 3'd2,
        ST_ERR1    = 3'd3,
        ST_ERR2    = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAITING = 2'd1,
        ST_LAST    = 2'd2
    } state_t;
`endif

    localparam int WCNT_W = 4;

    function automatic logic is_active(input trans_t t);
        return (t == TRANS_NONSEQ) || (t == TRANS_SEQ);
    endfunction

endpackage

// File: rtl/rv_sram_1rw.sv
// Single-port DEPTH x 32 storage: synchronous write, combinational read.
// Contents are deliberately not reset.
module rv_sram_1rw #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/rv_ahb_sram_slv.sv
// AHB-style SRAM slave with a fixed number of wait states per data phase.
// Optional feature macro: RV_AHB_SLV_ERR_EN adds RESP and an ERROR response
// for misaligned or out-of-range accesses.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no data phase in progress, RDY=1
// WAITING | data phase stalled, RDY=0, wait counter running down
// LAST    | final data-phase cycle, RDY=1, read data driven / write commits
// ERR1    | first ERROR cycle, RESP=1, RDY=0           (RV_AHB_SLV_ERR_EN)
// ERR2    | second ERROR cycle, RESP=1, RDY=1          (RV_AHB_SLV_ERR_EN)
module rv_ahb_sram_slv
    import rv_ahb_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int WAIT  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] A,
    input  logic [1:0]  TRANS,
    input  logic        WRITE,
    input  logic        SEL,
    input  logic        RDY_IN,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        RDY
`ifdef RV_AHB_SLV_ERR_EN
    ,
    output logic        RESP
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [WCNT_W-1:0] WLOAD = (WAIT > 0) ? WCNT_W'(WAIT - 1) : '0;

    state_t            state_q, state_d;
    logic [WCNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic              wr_q, wr_d;
    logic              mem_we;
    logic [31:0]       mem_rdata;
    logic              accept;
    logic              bad_addr;
    trans_t            trans;

    assign trans = trans_t'(TRANS);

`ifdef RV_AHB_SLV_ERR_EN
    assign bad_addr = (A[1:0] != 2'b00) || ((A >> (AW + 2)) != 32'd0);
`else
    logic unused_a;
    assign bad_addr = 1'b0;
    assign unused_a = ^{A >> (AW + 2), A[1:0]};
`endif

    // state, wait counter and address-phase capture registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
        end
    end

    // next-state, data-phase outputs and new address-phase acceptance
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        RDY     = 1'b1;
        RD      = 32'd0;
        mem_we  = 1'b0;
`ifdef RV_AHB_SLV_ERR_EN
        RESP    = RESP_OKAY;
`endif
        case (state_q)
            ST_WAITING: begin
                RDY = 1'b0;
                if (cnt_q == '0) begin
                    state_d = ST_LAST;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_LAST: begin
                mem_we  = wr_q;
                RD      = wr_q ? 32'd0 : mem_rdata;
                state_d = ST_IDLE;
            end
`ifdef RV_AHB_SLV_ERR_EN
            ST_ERR1: begin
                RDY     = 1'b0;
                RESP    = RESP_ERROR;
                state_d = ST_ERR2;
            end
            ST_ERR2: begin
                RESP    = RESP_ERROR;
                state_d = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // a new address phase is only taken while this slave is not stalling
        accept = RDY && SEL && RDY_IN && is_active(trans);
        if (accept) begin
            idx_d = A[AW+1:2];
            wr_d  = WRITE;
`ifdef RV_AHB_SLV_ERR_EN
            if (bad_addr) begin
                state_d = ST_ERR1;
            end else
`endif
            if (WAIT > 0) begin
                state_d = ST_WAITING;
                cnt_d   = WLOAD;
            end else begin
                state_d = ST_LAST;
            end
        end
    end

    rv_sram_1rw #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (idx_q),
        .wdata (WD),
        .rdata (mem_rdata)
    );

endmodule
